// File: rtl/tl_pkg.sv
// Shared definitions for the country-road sensor and the highway/country light controller.
// Light encodings, boolean constants and the controller's state encodings.
package tl_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser, persistence debouncer and one-cycle rising-edge pulse
// for the raw country-road loop detector.
module sensor_debounce
   import tl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam logic [7:0] DCNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       deb_q, deb_d;
   logic       deb_dly_q, deb_dly_d;
   logic [7:0] dcnt_q, dcnt_d;

   // The level only flips after the synchronised input has disagreed with it
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      s1_d      = din;
      s2_d      = s1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      dcnt_d    = dcnt_q;
      if (s2_q == deb_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
         deb_d  = s2_q;
         dcnt_d = '0;
      end else begin
         dcnt_d = dcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         s1_q      <= FALSE;
         s2_q      <= FALSE;
         deb_q     <= FALSE;
         deb_dly_q <= FALSE;
         dcnt_q    <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         dcnt_q    <= dcnt_d;
      end
   end

   assign level = deb_q;
   assign rise  = deb_q & ~deb_dly_q;

endmodule

// File: rtl/car_sensor.sv
// Country-road car sensor: debounced arrivals, green-light departures and the waiting-car queue.
// Optional CAR_SENSOR_STATS_EN adds a 16-bit wrapping total_cars arrival counter.
module car_sensor
   import tl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 4,
   parameter int DEP_CYCLES      = 3
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             sensor_raw,
   input  logic [1:0]       cntry,
   output logic             X,
   output logic [CNT_W-1:0] car_count,
   output logic             overflow
`ifdef CAR_SENSOR_STATS_EN
   ,
   output logic [15:0]      total_cars
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [7:0]       DEP_LAST = 8'(DEP_CYCLES - 1);

   logic             arr;
   logic             deb_level_unused;
   logic             green_busy;
   logic             dep;
   logic [7:0]       dep_tmr_q, dep_tmr_d;
   logic [CNT_W-1:0] car_count_q, car_count_d;
   logic             overflow_q, overflow_d;

   sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock(clock),
      .clear(clear),
      .din  (sensor_raw),
      .level(deb_level_unused),
      .rise (arr)
   );

   // Departures only accrue while green with someone waiting; YELLOW, RED
   // and the unused code all drop partial progress.
   assign green_busy = (cntry == GREEN) && (car_count_q != '0);

   always_comb begin
      dep       = FALSE;
      dep_tmr_d = '0;
      if (green_busy) begin
         if (dep_tmr_q == DEP_LAST) begin
            dep = TRUE;
         end else begin
            dep_tmr_d = dep_tmr_q + 8'd1;
         end
      end
   end

   always_comb begin
      car_count_d = car_count_q;
      overflow_d  = overflow_q;
      if (arr && !dep) begin
         if (car_count_q == CNT_MAX) begin
            overflow_d = TRUE;
         end else begin
            car_count_d = car_count_q + CNT_W'(1);
         end
      end else if (dep && !arr) begin
         car_count_d = car_count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         dep_tmr_q   <= '0;
         car_count_q <= '0;
         overflow_q  <= FALSE;
      end else begin
         dep_tmr_q   <= dep_tmr_d;
         car_count_q <= car_count_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef CAR_SENSOR_STATS_EN
   logic [15:0] total_q, total_d;

   // Counts every debounced arrival, including those dropped at a full queue.
   always_comb begin
      total_d = total_q;
      if (arr) begin
         total_d = total_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign total_cars = total_q;
`endif

   assign X         = (car_count_q != '0);
   assign car_count = car_count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_car_sensor.sv
// Bench for car_sensor: directed table, hand sequences and random traffic against a reference model.
module tb_car_sensor;
   import tl_pkg::*;

   localparam int DEB  = 4;
   localparam int CW   = 4;
   localparam int DEP  = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          clear;
   logic          sensor_raw;
   logic [1:0]    cntry;
   logic          X;
   logic [CW-1:0] car_count;
   logic          overflow;
`ifdef CAR_SENSOR_STATS_EN
   logic [15:0]   total_cars;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   car_sensor #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CW),
      .DEP_CYCLES     (DEP)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .sensor_raw(sensor_raw),
      .cntry     (cntry),
      .X         (X),
      .car_count (car_count),
      .overflow  (overflow)
`ifdef CAR_SENSOR_STATS_EN
      ,
      .total_cars(total_cars)
`endif
   );

   // Reference model: sampled-input delay line, sliding window of the last DEB
   // synchronised samples, green run length and plain integer queue count.
   int m_count;
   bit m_ovf;
   bit m_deb;
   bit m_deb_prev;
   bit sync_q[$];
   bit win[$];
   int run;
   int m_total;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_edge(input bit raw, input logic [1:0] light, input bit clr);
      bit arr, dep, s2, flip;
      if (clr) begin
         m_count = 0; m_ovf = 0; m_deb = 0; m_deb_prev = 0;
         sync_q = '{1'b0, 1'b0};
         win.delete();
         run = 0; m_total = 0;
         return;
      end
      arr = m_deb & ~m_deb_prev;
      dep = 0;
      if (light == GREEN && m_count > 0) begin
         run++;
         if (run == DEP) begin
            dep = 1;
            run = 0;
         end
      end else begin
         run = 0;
      end
      if (arr && !dep) begin
         if (m_count == CMAX) m_ovf = 1;
         else m_count++;
      end else if (dep && !arr) begin
         m_count--;
      end
      if (arr) m_total = (m_total + 1) % 65536;
      s2 = sync_q.pop_front();
      sync_q.push_back(raw);
      m_deb_prev = m_deb;
      win.push_back(s2);
      if (win.size() > DEB) void'(win.pop_front());
      if (win.size() == DEB) begin
         flip = 1;
         foreach (win[i]) if (win[i] == m_deb) flip = 0;
         if (flip) m_deb = ~m_deb;
      end
   endfunction

   task automatic tick(input bit raw, input logic [1:0] light, input bit clr);
      @(negedge clock);
      sensor_raw = raw;
      cntry      = light;
      clear      = clr;
      @(posedge clock);
      model_edge(raw, light, clr);
      #1;
      chk("model_count", int'(car_count), m_count);
      chk("model_x", int'(X), int'(m_count != 0));
      chk("model_overflow", int'(overflow), int'(m_ovf));
`ifdef CAR_SENSOR_STATS_EN
      chk("model_total", int'(total_cars), m_total);
`endif
   endtask

   typedef struct {
      int         hi;
      int         lo;
      logic [1:0] light;
      int         hold;
      int         exp_count;
      bit         exp_x;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int  raw_left, light_left;
      bit  rraw;
      logic [1:0] rlight;

      vecs[0]  = '{3,  10, RED,    0, 0, 0, 0};
      vecs[1]  = '{10, 10, RED,    0, 1, 1, 0};
      vecs[2]  = '{10, 10, RED,    0, 2, 1, 0};
      vecs[3]  = '{10, 10, RED,    0, 3, 1, 0};
      vecs[4]  = '{0,  0,  GREEN,  9, 0, 0, 0};
      vecs[5]  = '{10, 10, RED,    0, 1, 1, 0};
      vecs[6]  = '{10, 10, RED,    0, 2, 1, 0};
      vecs[7]  = '{0,  0,  GREEN,  2, 2, 1, 0};
      vecs[8]  = '{0,  0,  YELLOW, 1, 2, 1, 0};
      vecs[9]  = '{0,  0,  GREEN,  3, 1, 1, 0};
      vecs[10] = '{0,  0,  2'b11,  5, 1, 1, 0};
      vecs[11] = '{10, 10, RED,    0, 2, 1, 0};

      clear      = 1'b1;
      sensor_raw = 1'b1;
      cntry      = RED;

      // Reset held two edges with the loop occupied, then released.
      tick(1, RED, 1);
      tick(1, RED, 1);
      chk("reset_count", int'(car_count), 0);
      chk("reset_x", int'(X), 0);
      chk("reset_overflow", int'(overflow), 0);
      repeat (6) tick(1, RED, 0);
      chk("first_arrival_not_early", int'(car_count), 0);
      tick(1, RED, 0);
      chk("first_arrival_latency", int'(car_count), 1);
      chk("first_arrival_x", int'(X), 1);
      tick(0, RED, 1);
      chk("reset_discards_queue", int'(car_count), 0);

      for (int i = 0; i < 12; i++) begin
         repeat (vecs[i].hi) tick(1, RED, 0);
         repeat (vecs[i].lo) tick(0, RED, 0);
         repeat (vecs[i].hold) tick(0, vecs[i].light, 0);
         chk($sformatf("vec%0d_count", i), int'(car_count), vecs[i].exp_count);
         chk($sformatf("vec%0d_x", i), int'(X), int'(vecs[i].exp_x));
         chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
      end

      // Arrival and departure land on the same edge at a count of 2.
      repeat (4) tick(1, RED, 0);
      repeat (3) tick(1, GREEN, 0);
      chk("simultaneous_count", int'(car_count), 2);
      repeat (10) tick(0, RED, 0);
      chk("after_simultaneous_count", int'(car_count), 2);

      // Sixteen more arrivals saturate a 4-bit queue.
      repeat (16) begin
         repeat (6) tick(1, RED, 0);
         repeat (6) tick(0, RED, 0);
      end
      chk("saturate_count", int'(car_count), 15);
      chk("saturate_overflow", int'(overflow), 1);
`ifdef CAR_SENSOR_STATS_EN
      chk("saturate_total", int'(total_cars), 23);
`endif
      repeat (45) tick(0, GREEN, 0);
      chk("drain_count", int'(car_count), 0);
      chk("drain_x", int'(X), 0);
      chk("drain_overflow_sticky", int'(overflow), 1);
      tick(0, RED, 1);
      chk("clear_overflow", int'(overflow), 0);

      // Random traffic with occasional clears, checked every cycle by the model.
      raw_left = 0;
      light_left = 0;
      rraw = 0;
      rlight = RED;
      for (int c = 0; c < 3000; c++) begin
         if (raw_left == 0) begin
            rraw = ~rraw;
            raw_left = $urandom_range(1, 12);
         end
         if (light_left == 0) begin
            rlight = 2'($urandom_range(0, 3));
            light_left = $urandom_range(1, 10);
         end
         tick(rraw, rlight, ($urandom_range(0, 399) == 0));
         raw_left--;
         light_left--;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/car_sensor.md
Name: car_sensor

Overview:
- Conditions the raw country-road loop detector and tracks the queue of waiting cars.
- Produces the car-present signal X consumed directly by the highway/country traffic-light controller; sits immediately upstream of it.
- Uses the controller's cntry light output as feedback to retire cars that drive off while the country light is green.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clock cycles the synchronised input must disagree with the debounced level before that level flips (legal range 2..255)
- CNT_W, 4, width of car_count; maximum queue is 2^CNT_W-1
- DEP_CYCLES, 3, cycles of continuous country GREEN needed to retire one car (legal range 1..255)

Ports:
- clock  in  1  single system clock; all state changes on its rising edge
- clear  in  1  synchronous active-high reset
- sensor_raw  in  1  asynchronous loop-detector input; high while a car is over the loop
- cntry  in  2  country light from the controller: RED=2'b00, YELLOW=2'b01, GREEN=2'b10
- X  out  1  car present on the country road; high when car_count != 0
- car_count  out  CNT_W  number of cars currently waiting
- overflow  out  1  sticky flag: an arrival was dropped because the queue was full
- total_cars  out  16  present only with CAR_SENSOR_STATS_EN

Behaviour:
- Reset (clear high at a rising edge):
  - sync flops, debounced level, debounce counter, departure timer, car_count and overflow all go to 0.
  - X=0 from the following cycle. Reset mid-operation discards any queued cars.
- Synchroniser: two-flop chain sensor_raw -> s1 -> s2.
- Debounce, per edge:
  - if s2 == deb: dcnt <= 0
  - else if dcnt == DEBOUNCE_CYCLES-1: deb <= s2, dcnt <= 0
  - else: dcnt <= dcnt+1
  - Any excursion of s2 shorter than DEBOUNCE_CYCLES cycles is ignored.
- Arrival pulse: arr = deb & ~deb_q, where deb_q is deb delayed one cycle. This gives one pulse per debounced rising edge.
- Arrival latency: raw high first sampled at edge k -> deb=1 after edge k+1+DEBOUNCE_CYCLES -> car_count increments at edge k+2+DEBOUNCE_CYCLES (edge k+6 at default).
- Departure timer:
  - Counts while cntry==GREEN and car_count != 0.
  - On reaching DEP_CYCLES-1 it asserts dep for one cycle and restarts from 0.
  - Clears to 0 whenever cntry != GREEN or car_count==0; partial progress is lost.
  - cntry values YELLOW, RED and 2'b11 all stop and clear the timer.
- Count update, per edge:
  - arr & dep: car_count unchanged
  - arr only, car_count < max: car_count+1
  - arr only, car_count == max: hold at max, overflow <= 1
  - dep only: car_count-1; dep never fires at 0
- overflow clears only on clear.
- X is driven combinationally from the car_count register: it rises the same cycle car_count becomes 1 and falls the same cycle car_count becomes 0.
- No combinational path exists from sensor_raw or cntry to any output.

Optional Feature:
- CAR_SENSOR_STATS_EN defined:
  - adds the total_cars port, a 16-bit counter incremented on every arr pulse, including dropped ones
  - wraps 16'hFFFF -> 0; reset to 0 by clear
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package tl_pkg, common with the controller:
  - light encodings RED/YELLOW/GREEN as a 2-bit typedef light_t
  - TRUE/FALSE constants
  - the controller's state encodings S0..S4
- Sub-module sensor_debounce, parameterised by DEBOUNCE_CYCLES:
  - contains the synchroniser, debounce counter and rising-edge pulse
  - ports: clock, clear, din, level, rise
- car_sensor instantiates one sensor_debounce and holds the queue counter, departure timer and flags.

Test Plan:
- Reset: clear=1 for 2 edges with sensor_raw=1 -> car_count=0, X=0, overflow=0; after release, car_count=1 at edge 6 past the first sample.
- Glitch: sensor_raw high for 3 cycles, DEBOUNCE_CYCLES=4 -> car_count stays 0, X stays 0.
- Three cars: three 10-cycle pulses separated by 10 low cycles -> car_count 1,2,3 and X=1; then cntry=GREEN -> car_count decrements every 3 cycles and X falls on the edge where the count reaches 0.
- Green interrupted: car_count=2, cntry=GREEN for 2 cycles then YELLOW -> no departure; GREEN again for 3 cycles -> car_count=1.
- Saturation: 16 arrivals with CNT_W=4 and cntry=RED -> car_count=15, overflow=1; overflow stays 1 after a drain to 0 and clears only on clear.
- Simultaneous: arr and dep on the same edge at car_count=2 -> count stays 2. With CAR_SENSOR_STATS_EN, total_cars counts all arrivals, including the dropped one in the saturation test.
